data_mem_access_unit: RTL and testbench
=======================================

// Module: data_mem_access_unit
// PURPOSE
//  Memory-stage sequencer. It drives the data memory for LOAD/STORE over a req/ack handshake.
//  It registers the load result that the writeback mux takes on its data-memory port.
//  It accepts one 20-bit one-hot opcode select per operation, with bit 2 = LOAD and bit 3 = STORE.
//  It also flags misaligned and timed-out accesses.
// PARAMETERS
//  DATA_W   32  data width of store_data, mem_wdata, mem_rdata, load_data
//  ADDR_W   32  address width
//  SEL_W    20  opcode one-hot select width
//  TIMEOUT  16  max cycles in REQ without mem_ack before abort (>=2)
// PORTS
//  clk          in   1        rising-edge clock
//  reset        in   1        asynchronous, active-high reset
//  op_valid     in   1        operation offered this cycle
//  op_ready     out  1        unit idle, offer accepted when op_valid & op_ready
//  op_select    in   SEL_W    one-hot opcode (bit2 LOAD, bit3 STORE)
//  op_addr      in   ADDR_W   effective byte address
//  store_data   in   DATA_W   STORE write data
//  mem_req      out  1        memory request, held until mem_ack or timeout
//  mem_we       out  1        1=write (STORE), 0=read (LOAD), stable while mem_req
//  mem_addr     out  ADDR_W   latched address, stable while mem_req
//  mem_wdata    out  DATA_W   latched store data, stable while mem_req
//  mem_ack      in   1        memory completes request this cycle
//  mem_rdata    in   DATA_W   read data, valid with mem_ack
//  load_data    out  DATA_W   registered load result, held until next successful LOAD
//  done         out  1        one-cycle completion pulse per accepted op
//  err          out  1        valid with done: misaligned or timeout
// BEHAVIOUR
//  Reset (async) sets: state=IDLE, op_ready=1, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0,
//   load_data=0, done=0, err=0, timeout count=0. An access in progress is abandoned and mem_req drops at once.
//  FSM states are IDLE, REQ and DONE.
//  IDLE: op_ready=1.
//   - Accept on op_valid. Latch addr/data; is_load=sel[2]; is_store=sel[3]&~sel[2] (LOAD wins if both set).
//   - Memory op with op_addr[1:0]!=0: go to DONE with err=1. No memory access.
//   - Aligned memory op: go to REQ.
//   - Non-memory op (neither bit set): go to DONE with err=0. No memory access, load_data untouched.
//  REQ: mem_req=1, op_ready=0, timeout count increments each cycle.
//   - mem_ack: on LOAD, load_data<=mem_rdata. Go to DONE with err=0.
//   - No ack when count reaches TIMEOUT-1: drop mem_req and go to DONE with err=1. load_data untouched.
//   - If ack arrives in that same last cycle, the ack wins (success).
//  DONE: done=1 and err valid for exactly one cycle, op_ready=0. Count clears. Next state is IDLE.
//  Latency: accept at cycle N. Ack in first REQ cycle -> done at N+2. Non-memory/misaligned -> done at N+1.
//  Throughput: at most one op per 2 cycles (non-memory) or 3 cycles (memory, zero-wait ack).
//  mem_ack outside REQ is ignored. op_valid outside IDLE is ignored (not accepted).
//  load_data is valid from the done cycle onward and is stable for the writeback mux.
// STRUCTURE
//  Shared package/include (cpu_defs): OP_LOAD=2, OP_STORE=3, SEL_W, state encodings S_IDLE/S_REQ/S_DONE.
//  The writeback mux uses the same OP_* constants.
//  One sub-module: mem_timeout_counter (clear, enable, TIMEOUT param, expire flag).
// TESTING
//  1 LOAD sel=20'h00004 addr=0x40, mem_rdata=0xDEADBEEF, ack in 1st REQ cycle
//    -> mem_req 1 cycle, mem_we=0, done at N+2, load_data=0xDEADBEEF, err=0.
//  2 STORE sel=20'h00008 addr=0x80 data=0x12345678, ack after 3 wait cycles
//    -> mem_we=1, mem_addr/wdata held stable 4 cycles, done err=0, load_data unchanged.
//  3 LOAD addr=0x41 -> no mem_req, done at N+1 with err=1.
//    ADD sel=20'h00001 -> done at N+1, err=0, no mem_req.
//  4 LOAD with no ack, TIMEOUT=16 -> mem_req high 16 cycles then low, done err=1, load_data unchanged.
//    Repeat with ack on 16th cycle -> success, err=0.
//  5 sel=20'h0000C (LOAD+STORE) -> treated as LOAD, mem_we=0.
//    op_valid held during REQ -> not accepted, op_ready=0.
//  6 reset asserted mid-REQ -> mem_req, done, load_data go to 0 asynchronously.
//    op_ready=1 after release, and a following LOAD completes normally.

Source files
------------

// File: rtl/data_mem_access_unit_pkg.sv
// Shared CPU definitions: opcode select bit positions and memory-stage state encodings.
// The writeback mux keys off the same OP_* constants.
package cpu_defs;

  localparam int SEL_W    = 20;
  localparam int OP_LOAD  = 2;
  localparam int OP_STORE = 3;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  typedef struct packed {
    logic is_load;
    logic is_store;
  } op_kind_t;

  // bits[0] is the LOAD select, bits[1] the STORE select; LOAD wins when both are set
  function automatic op_kind_t decode_op(input logic [1:0] bits);
    op_kind_t k;
    k.is_load  = bits[0];
    k.is_store = bits[1] & ~bits[0];
    return k;
  endfunction

endpackage

// File: rtl/mem_timeout_counter.sv
// Counts cycles spent waiting for a memory acknowledge; expire marks the last allowed cycle.
module mem_timeout_counter #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  logic [CNT_W-1:0] count;

  assign expire = (count == CNT_W'(TIMEOUT - 1));

  // saturate at the expiry value so a stalled sequencer never wraps
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expire) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/data_mem_access_unit.sv
// Memory-stage sequencer: runs LOAD/STORE over a req/ack handshake, registers the load
// result for writeback and reports misaligned or timed-out accesses with the done pulse.
module data_mem_access_unit #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int SEL_W   = 20,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [SEL_W-1:0]  op_select,
  input  logic [ADDR_W-1:0] op_addr,
  input  logic [DATA_W-1:0] store_data,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] load_data,
  output logic              done,
  output logic              err
);

  import cpu_defs::*;

  logic [1:0] state;
  logic       is_load_q;
  logic       expire;
  op_kind_t   kind;
  logic       is_mem;
  logic       misaligned;
  logic       unused_sel;

  // only the LOAD/STORE select bits matter here; the rest belong to other units
  assign unused_sel = ^op_select;

  assign kind       = decode_op(op_select[OP_STORE:OP_LOAD]);
  assign is_mem     = kind.is_load | kind.is_store;
  assign misaligned = (op_addr[1:0] != 2'b00);

  assign op_ready = (state == S_IDLE);
  assign mem_req  = (state == S_REQ);
  assign done     = (state == S_DONE);

  mem_timeout_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk    (clk),
    .reset  (reset),
    .clear  (state != S_REQ),
    .enable (state == S_REQ),
    .expire (expire)
  );

  // an ack in the final allowed cycle still counts as success, so it is tested before expiry
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      is_load_q <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      load_data <= '0;
      err       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (op_valid) begin
            mem_addr  <= op_addr;
            mem_wdata <= store_data;
            mem_we    <= kind.is_store;
            is_load_q <= kind.is_load;
            if (is_mem && misaligned) begin
              state <= S_DONE;
              err   <= 1'b1;
            end else if (is_mem) begin
              state <= S_REQ;
            end else begin
              state <= S_DONE;
              err   <= 1'b0;
            end
          end
        end
        S_REQ: begin
          if (mem_ack) begin
            if (is_load_q) begin
              load_data <= mem_rdata;
            end
            state <= S_DONE;
            err   <= 1'b0;
          end else if (expire) begin
            state <= S_DONE;
            err   <= 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          err   <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          err   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_access_unit.sv
// Directed plus randomized bench for data_mem_access_unit against a per-operation
// outcome model (request length, done latency, error flag, load result).
module tb_data_mem_access_unit;

  localparam int TIMEOUT = 16;

  logic        clk;
  logic        reset;
  logic        op_valid;
  logic        op_ready;
  logic [19:0] op_select;
  logic [31:0] op_addr;
  logic [31:0] store_data;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [31:0] load_data;
  logic        done;
  logic        err;

  int          vectors;
  int          miscompares;
  logic [31:0] modelLoad;

  data_mem_access_unit #(
    .DATA_W  (32),
    .ADDR_W  (32),
    .SEL_W   (20),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .op_valid   (op_valid),
    .op_ready   (op_ready),
    .op_select  (op_select),
    .op_addr    (op_addr),
    .store_data (store_data),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .load_data  (load_data),
    .done       (done),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed 0x%08h required 0x%08h", tag, observed, expected);
    end
  endtask

  // One operation end to end; ackAt is the 1-based request cycle carrying mem_ack (0 = never)
  task automatic applyStimulus(input logic [19:0] sel, input logic [31:0] addr, input logic [31:0] data,
                               input int ackAt, input logic [31:0] rdata, input bit holdValid);
    bit          isLoad, isStore, isMem, misal;
    int          expReq, expDone;
    logic        expErr;
    logic [31:0] nextLoad;
    int          reqSeen, doneAt;
    logic        errSeen;
    logic [31:0] loadSeen;

    isLoad  = sel[2];
    isStore = sel[3] && !sel[2];
    isMem   = isLoad || isStore;
    misal   = isMem && (addr[1:0] != 2'b00);
    nextLoad = modelLoad;
    if (!isMem || misal) begin
      expReq = 0; expDone = 1; expErr = misal;
    end else if (ackAt >= 1 && ackAt <= TIMEOUT) begin
      expReq = ackAt; expDone = ackAt + 1; expErr = 1'b0;
      if (isLoad) nextLoad = rdata;
    end else begin
      expReq = TIMEOUT; expDone = TIMEOUT + 1; expErr = 1'b1;
    end

    @(negedge clk);
    checkOutput("ready_idle", {31'b0, op_ready}, 32'd1);
    op_valid   = 1'b1;
    op_select  = sel;
    op_addr    = addr;
    store_data = data;
    mem_ack    = 1'($urandom_range(0, 1));
    mem_rdata  = $urandom();

    reqSeen = 0; doneAt = 0; errSeen = 1'bx; loadSeen = 'x;
    for (int c = 1; c <= 40 && doneAt == 0; c++) begin
      @(negedge clk);
      op_valid = holdValid;
      if (done) begin
        doneAt   = c;
        errSeen  = err;
        loadSeen = load_data;
        op_valid = 1'b0;
        mem_ack  = 1'($urandom_range(0, 1));
        mem_rdata = $urandom();
      end else if (mem_req) begin
        reqSeen++;
        checkOutput("req_addr", mem_addr, addr);
        checkOutput("req_wdata", mem_wdata, data);
        checkOutput("req_we", {31'b0, mem_we}, {31'b0, isStore});
        checkOutput("req_ready", {31'b0, op_ready}, 32'd0);
        mem_ack   = (reqSeen == ackAt);
        mem_rdata = (reqSeen == ackAt) ? rdata : $urandom();
      end else begin
        mem_ack = 1'b0;
      end
    end
    modelLoad = nextLoad;

    checkOutput("req_cycles", 32'(reqSeen), 32'(expReq));
    checkOutput("done_cycle", 32'(doneAt), 32'(expDone));
    checkOutput("done_err", {31'b0, errSeen}, {31'b0, expErr});
    checkOutput("done_load", loadSeen, modelLoad);

    @(negedge clk);
    mem_ack  = 1'b0;
    op_valid = 1'b0;
    checkOutput("done_pulse", {31'b0, done}, 32'd0);
    checkOutput("ready_after", {31'b0, op_ready}, 32'd1);
    checkOutput("req_after", {31'b0, mem_req}, 32'd0);
    checkOutput("load_held", load_data, modelLoad);
  endtask

  initial begin
    logic [19:0] one;
    logic [19:0] sel;
    logic [31:0] addr;
    int          ackAt;
    int          pick;

    vectors = 0; miscompares = 0; modelLoad = 32'h0;
    one = 20'h1;
    reset = 1'b1; op_valid = 1'b0; op_select = '0; op_addr = '0;
    store_data = '0; mem_ack = 1'b0; mem_rdata = '0;

    #2;
    checkOutput("rst_ready", {31'b0, op_ready}, 32'd1);
    checkOutput("rst_req", {31'b0, mem_req}, 32'd0);
    checkOutput("rst_we", {31'b0, mem_we}, 32'd0);
    checkOutput("rst_addr", mem_addr, 32'h0);
    checkOutput("rst_wdata", mem_wdata, 32'h0);
    checkOutput("rst_load", load_data, 32'h0);
    checkOutput("rst_done", {31'b0, done}, 32'd0);
    checkOutput("rst_err", {31'b0, err}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    $display("[TB] directed operations");
    applyStimulus(20'h00004, 32'h40, 32'h0, 1, 32'hDEADBEEF, 1'b0);
    applyStimulus(20'h00008, 32'h80, 32'h12345678, 4, 32'h55AA55AA, 1'b0);
    applyStimulus(20'h00004, 32'h41, 32'h0, 1, 32'h11111111, 1'b0);
    applyStimulus(20'h00008, 32'h82, 32'h9999, 1, 32'h22222222, 1'b0);
    applyStimulus(20'h00001, 32'h100, 32'h0, 1, 32'h33333333, 1'b0);
    applyStimulus(20'h00004, 32'h200, 32'h0, 0, 32'h44444444, 1'b0);
    applyStimulus(20'h00004, 32'h204, 32'h0, TIMEOUT, 32'hCAFEF00D, 1'b0);
    applyStimulus(20'h0000C, 32'h300, 32'hAAAA5555, 2, 32'h0BADF00D, 1'b1);

    $display("[TB] reset during a request");
    @(negedge clk);
    op_valid = 1'b1; op_select = 20'h00004; op_addr = 32'h500;
    @(negedge clk);
    op_valid = 1'b0;
    @(negedge clk);
    checkOutput("pre_rst_req", {31'b0, mem_req}, 32'd1);
    reset = 1'b1;
    #1;
    modelLoad = 32'h0;
    checkOutput("mid_rst_req", {31'b0, mem_req}, 32'd0);
    checkOutput("mid_rst_done", {31'b0, done}, 32'd0);
    checkOutput("mid_rst_load", load_data, modelLoad);
    checkOutput("mid_rst_ready", {31'b0, op_ready}, 32'd1);
    @(negedge clk);
    reset = 1'b0;
    applyStimulus(20'h00004, 32'h600, 32'h0, 2, 32'h76543210, 1'b0);

    $display("[TB] randomized operations");
    for (int n = 0; n < 40; n++) begin
      pick = $urandom_range(0, 4);
      case (pick)
        0: sel = 20'h00004;
        1: sel = 20'h00008;
        2: sel = 20'h0000C;
        3: sel = one << $urandom_range(4, 19);
        default: sel = one << $urandom_range(0, 1);
      endcase
      addr = $urandom();
      if ($urandom_range(0, 3) != 0) addr[1:0] = 2'b00;
      pick = $urandom_range(0, 9);
      if (pick == 0)      ackAt = 0;
      else if (pick == 1) ackAt = TIMEOUT;
      else if (pick == 2) ackAt = TIMEOUT + 1;
      else                ackAt = $urandom_range(1, 4);
      applyStimulus(sel, addr, $urandom(), ackAt, $urandom(), 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
